// File: rtl/peripheral_bus_if.sv
// peripheral_bus_if: master-side access request and decoder completion/read-data signals.
interface peripheral_bus_if;
  logic        peripheralEnable;
  logic [15:0] peripheralBus_address;
  logic        peripheralBus_busy;
  logic [31:0] peripheralBus_dataRead;
  modport master (output peripheralEnable, peripheralBus_address, input peripheralBus_busy, peripheralBus_dataRead);
  modport slave (input peripheralEnable, peripheralBus_address, output peripheralBus_busy, peripheralBus_dataRead);
endinterface

// File: rtl/peripheral_bus_decoder.sv
// peripheral_bus_decoder: routes master accesses to device slots by ID, aborts stuck accesses, records first error.
module peripheral_bus_decoder #(
  parameter int DEVICE_COUNT   = 4,
  parameter int ID_BASE        = 0,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  peripheral_bus_if.slave           bus,
  output logic [11:0]               localAddress,
  output logic [DEVICE_COUNT-1:0]   deviceEnable,
  input  logic [DEVICE_COUNT-1:0]   deviceBusy,
  input  logic [32*DEVICE_COUNT-1:0] deviceDataRead,
  input  logic                      errorClear,
  output logic                      errorFlag,
  output logic [1:0]                errorType,
  output logic [15:0]               errorAddress
);
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int IW = DEVICE_COUNT > 1 ? $clog2(DEVICE_COUNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, WAIT, ABORT} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [IW-1:0] idx, idx_d, hit_idx, sel;
  logic hit;
  logic [1:0] err_ev;
  assign localAddress = bus.peripheralBus_address[11:0];
  // 5-bit compare so slots whose ID would pass 15 never match
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEVICE_COUNT; i++)
      if ({1'b0, bus.peripheralBus_address[15:12]} == 5'(ID_BASE + i)) begin
        hit = 1'b1;
        hit_idx = IW'(i);
      end
  end
  assign sel = state == WAIT ? idx : hit_idx;
  always_comb begin
    deviceEnable = '0;
    bus.peripheralBus_busy = 1'b0;
    bus.peripheralBus_dataRead = '0;
    state_d = state;
    cnt_d = cnt;
    idx_d = idx;
    err_ev = 2'b00;
    case (state)
      IDLE: if (bus.peripheralEnable) begin
        if (hit) begin
          deviceEnable[sel] = 1'b1;
          bus.peripheralBus_busy = deviceBusy[sel];
          bus.peripheralBus_dataRead = deviceDataRead[32*sel +: 32];
          if (deviceBusy[sel]) begin
            state_d = WAIT;
            idx_d = sel;
            cnt_d = CW'(1);
          end
        end else begin
          bus.peripheralBus_dataRead = '1;
          err_ev = 2'b01;
        end
      end
      WAIT: if (!bus.peripheralEnable) begin
        state_d = IDLE;
        cnt_d = '0;
      end else begin
        deviceEnable[sel] = 1'b1;
        bus.peripheralBus_busy = deviceBusy[sel];
        bus.peripheralBus_dataRead = deviceDataRead[32*sel +: 32];
        if (!deviceBusy[sel]) begin
          state_d = IDLE;
          cnt_d = '0;
        end else if (cnt >= LAST - 1'b1) begin
          state_d = ABORT;
          cnt_d = LAST;
        end else cnt_d = cnt + 1'b1;
      end
      ABORT: begin
        bus.peripheralBus_dataRead = bus.peripheralEnable ? '1 : '0;
        err_ev = 2'b10;
        state_d = IDLE;
        cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      errorFlag <= 1'b0;
      errorType <= 2'b00;
      errorAddress <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      idx <= idx_d;
      if (err_ev != 2'b00 && (!errorFlag || errorClear)) begin
        errorFlag <= 1'b1;
        errorType <= err_ev;
        errorAddress <= bus.peripheralBus_address;
      end else if (errorClear) begin
        errorFlag <= 1'b0;
        errorType <= 2'b00;
        errorAddress <= '0;
      end
    end
  end
endmodule

// File: tb/tb_peripheral_bus_decoder.sv
// tb_peripheral_bus_decoder: table vectors, directed error/timeout/reset sequences, randomized accesses vs access-level model.
module tb_peripheral_bus_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  peripheral_bus_if pbus();
  logic [11:0] local_addr;
  logic [3:0] dev_en, dev_busy;
  logic [127:0] dev_data;
  logic err_clr, err_flag;
  logic [1:0] err_type;
  logic [15:0] err_addr;
  peripheral_bus_decoder #(.DEVICE_COUNT(4), .ID_BASE(2), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(pbus), .localAddress(local_addr),
    .deviceEnable(dev_en), .deviceBusy(dev_busy), .deviceDataRead(dev_data),
    .errorClear(err_clr), .errorFlag(err_flag), .errorType(err_type), .errorAddress(err_addr));
  localparam logic [127:0] DATA = {32'hCAFE0003, 32'hBEEF0002, 32'h12345678, 32'hF00D0000};
  localparam logic [31:0] ONES = 32'hFFFFFFFF;
  int checks = 0, failures = 0;
  logic m_flag;
  logic [1:0] m_type;
  logic [15:0] m_addr;
  typedef struct {
    logic en;
    logic [15:0] addr;
    logic [3:0] dbusy;
    logic [3:0] eden;
    logic ebusy;
    logic [31:0] edata;
  } vec_t;
  vec_t tbl[6];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic errchk(input logic f, input logic [1:0] t, input logic [15:0] a);
    chk("errflag_explicit", 32'(err_flag), 32'(f));
    chk("errtype_explicit", 32'(err_type), 32'(t));
    chk("erraddr_explicit", 32'(err_addr), 32'(a));
  endtask
  task automatic drive(input logic en, input logic [15:0] a, input logic [3:0] b, input logic c);
    pbus.peripheralEnable = en;
    pbus.peripheralBus_address = a;
    dev_busy = b;
    err_clr = c;
  endtask
  // one clock: compare combinational outputs mid-cycle, then advance the error model across the edge
  task automatic cyc(input logic [3:0] eden, input logic ebusy, input logic [31:0] edata, input logic [1:0] ev);
    @(negedge clk);
    chk("deviceEnable", 32'(dev_en), 32'(eden));
    chk("busy", 32'(pbus.peripheralBus_busy), 32'(ebusy));
    chk("dataRead", pbus.peripheralBus_dataRead, edata);
    chk("localAddress", 32'(local_addr), 32'(pbus.peripheralBus_address[11:0]));
    chk("errorFlag", 32'(err_flag), 32'(m_flag));
    chk("errorType", 32'(err_type), 32'(m_type));
    chk("errorAddress", 32'(err_addr), 32'(m_addr));
    if (!rst_n) begin
      m_flag = 1'b0; m_type = 2'b00; m_addr = 16'h0;
    end else if (ev != 2'b00 && (!m_flag || err_clr)) begin
      m_flag = 1'b1; m_type = ev; m_addr = pbus.peripheralBus_address;
    end else if (err_clr) begin
      m_flag = 1'b0; m_type = 2'b00; m_addr = 16'h0;
    end
    @(posedge clk);
    #1;
    err_clr = 1'b0;
  endtask
  logic [3:0] id;
  logic [15:0] a;
  logic hit;
  int s, d, drop;
  initial begin
    m_flag = 1'b0; m_type = 2'b00; m_addr = 16'h0;
    dev_data = DATA;
    drive(1'b0, 16'h0000, 4'b0000, 1'b0);
    tbl[0] = '{1'b1, 16'h3ABC, 4'b0000, 4'b0010, 1'b0, 32'h12345678};
    tbl[1] = '{1'b0, 16'h3ABC, 4'b0000, 4'b0000, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 16'h2000, 4'b1110, 4'b0001, 1'b0, 32'hF00D0000};
    tbl[3] = '{1'b1, 16'h5FFF, 4'b0111, 4'b1000, 1'b0, 32'hCAFE0003};
    tbl[4] = '{1'b1, 16'h4123, 4'b1011, 4'b0100, 1'b0, 32'hBEEF0002};
    tbl[5] = '{1'b0, 16'h5555, 4'b1111, 4'b0000, 1'b0, 32'h0};
    #1;
    errchk(1'b0, 2'b00, 16'h0);
    cyc(4'b0000, 1'b0, 32'h0, 2'b00);
    rst_n = 1'b1;
    cyc(4'b0000, 1'b0, 32'h0, 2'b00);
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].en, tbl[i].addr, tbl[i].dbusy, 1'b0);
      cyc(tbl[i].eden, tbl[i].ebusy, tbl[i].edata, 2'b00);
    end
    errchk(1'b0, 2'b00, 16'h0);
    drive(1'b1, 16'h7000, 4'b0000, 1'b0);
    cyc(4'b0000, 1'b0, ONES, 2'b01);
    errchk(1'b1, 2'b01, 16'h7000);
    drive(1'b1, 16'h3123, 4'b0010, 1'b0);
    for (int k = 0; k < 7; k++) cyc(4'b0010, 1'b1, 32'h12345678, 2'b00);
    cyc(4'b0000, 1'b0, ONES, 2'b10);
    errchk(1'b1, 2'b01, 16'h7000);
    drive(1'b1, 16'hF000, 4'b0000, 1'b1);
    cyc(4'b0000, 1'b0, ONES, 2'b01);
    errchk(1'b1, 2'b01, 16'hF000);
    drive(1'b1, 16'h3000, 4'b0010, 1'b0);
    cyc(4'b0010, 1'b1, 32'h12345678, 2'b00);
    cyc(4'b0010, 1'b1, 32'h12345678, 2'b00);
    rst_n = 1'b0;
    m_flag = 1'b0; m_type = 2'b00; m_addr = 16'h0;
    #1;
    errchk(1'b0, 2'b00, 16'h0);
    cyc(4'b0010, 1'b1, 32'h12345678, 2'b00);
    rst_n = 1'b1;
    drive(1'b1, 16'h2000, 4'b0000, 1'b0);
    cyc(4'b0001, 1'b0, 32'hF00D0000, 2'b00);
    errchk(1'b0, 2'b00, 16'h0);
    drive(1'b1, 16'h3123, 4'b0010, 1'b0);
    for (int k = 0; k < 7; k++) cyc(4'b0010, 1'b1, 32'h12345678, 2'b00);
    cyc(4'b0000, 1'b0, ONES, 2'b10);
    errchk(1'b1, 2'b10, 16'h3123);
    drive(1'b1, 16'h4000, 4'b0000, 1'b0);
    cyc(4'b0100, 1'b0, 32'hBEEF0002, 2'b00);
    errchk(1'b1, 2'b10, 16'h3123);
    drive(1'b0, 16'h0000, 4'b0000, 1'b1);
    cyc(4'b0000, 1'b0, 32'h0, 2'b00);
    errchk(1'b0, 2'b00, 16'h0);
    drive(1'b1, 16'h5000, 4'b1000, 1'b0);
    cyc(4'b1000, 1'b1, 32'hCAFE0003, 2'b00);
    cyc(4'b1000, 1'b1, 32'hCAFE0003, 2'b00);
    drive(1'b0, 16'h5000, 4'b1000, 1'b0);
    cyc(4'b0000, 1'b0, 32'h0, 2'b00);
    drive(1'b1, 16'h5000, 4'b0000, 1'b0);
    cyc(4'b1000, 1'b0, 32'hCAFE0003, 2'b00);
    errchk(1'b0, 2'b00, 16'h0);
    // random accesses: slot holds busy for its first d cycles; a busy run reaching the 8th cycle is aborted
    for (int n = 0; n < 80; n++) begin
      id = 4'($urandom_range(0, 15));
      a = {id, 12'($urandom)};
      hit = id >= 4'd2 && id <= 4'd5;
      s = int'(id) - 2;
      d = $urandom_range(0, 9);
      drop = ($urandom_range(0, 4) == 0) ? $urandom_range(2, 7) : 0;
      for (int k = 1; k <= 8; k++) begin
        pbus.peripheralBus_address = (k == 1) ? a : 16'($urandom);
        dev_data = {$urandom, $urandom, $urandom, $urandom};
        dev_busy = 4'($urandom);
        if (hit) dev_busy[s] = (k <= d);
        err_clr = ($urandom_range(0, 7) == 0);
        if (k == drop) begin
          pbus.peripheralEnable = 1'b0;
          cyc(4'b0000, 1'b0, 32'h0, 2'b00);
          break;
        end
        pbus.peripheralEnable = 1'b1;
        if (!hit) begin
          cyc(4'b0000, 1'b0, ONES, 2'b01);
          break;
        end
        if (k == 8) begin
          cyc(4'b0000, 1'b0, ONES, 2'b10);
          break;
        end
        cyc(4'(1 << s), k <= d, dev_data[32*s +: 32], 2'b00);
        if (k > d) break;
      end
      pbus.peripheralEnable = 1'b0;
      pbus.peripheralBus_address = 16'($urandom);
      dev_busy = 4'($urandom);
      err_clr = ($urandom_range(0, 3) == 0);
      cyc(4'b0000, 1'b0, 32'h0, 2'b00);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/peripheral_bus_decoder.md
PERIPHERAL_BUS_DECODER -- requirements
Module: peripheral_bus_decoder

Interface
REQ-001 SHALL have parameter DEVICE_COUNT, default 4: number of device slots, legal range 1..16.
REQ-002 SHALL have parameter ID_BASE, default 0: 4-bit ID of slot 0; slot i uses ID_BASE+i.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256: busy cycles allowed before abort, legal range 2..65535.
REQ-004 SHALL have ports, clock and reset first:
clk  input  1  system clock; all state on rising edge.
rst_n  input  1  asynchronous active-low reset.
peripheralEnable  input  1  master access request, held until completion.
peripheralBus_address  input  16  [15:12] device ID, [11:0] local address.
peripheralBus_busy  output  1  access not yet complete.
peripheralBus_dataRead  output  32  read data returned to master.
localAddress  output  12  peripheralBus_address[11:0].
deviceEnable  output  DEVICE_COUNT  one-hot slot select.
deviceBusy  input  DEVICE_COUNT  per-slot busy.
deviceDataRead  input  32*DEVICE_COUNT  per-slot read data, slot i at [32i+31:32i].
errorClear  input  1  single-cycle clear of error status.
errorFlag  output  1  sticky error.
errorType  output  2  01 unmapped, 10 timeout, 00 none.
errorAddress  output  16  address of the first error since clear.

Function
REQ-005 SHALL treat an address as a hit on slot i when address[15:12] == ID_BASE+i (4-bit compare, no wrap past 15) and i < DEVICE_COUNT; anything else is unmapped.
REQ-006 SHALL implement the states IDLE, WAIT and ABORT; reset state is IDLE.
REQ-007 In IDLE with a hit on enable: deviceEnable[i] high in the same cycle, busy = deviceBusy[i], dataRead = slot i data, all combinational.
REQ-008 In IDLE with a hit and deviceBusy[i]=1, the block SHALL latch i, load counter=1 and enter WAIT.
REQ-009 In WAIT the block SHALL route the latched slot regardless of address changes; on deviceBusy low it SHALL return to IDLE, with completion visible that cycle.
REQ-010 In WAIT, if enable drops, the block SHALL return to IDLE without flagging an error.
REQ-011 In WAIT, when the counter reaches TIMEOUT_CYCLES-1 and busy is still high, the block SHALL enter ABORT and SHALL NOT increment past that value.
REQ-012 ABORT, exactly 1 cycle:
- deviceEnable all 0, busy=0, dataRead=32'hFFFFFFFF.
- timeout error recorded.
- next state IDLE.
REQ-013 Unmapped access in IDLE with enable:
- completes the same cycle: busy=0, dataRead=32'hFFFFFFFF, deviceEnable all 0.
- unmapped error recorded.
- state stays IDLE.
REQ-014 Error recording:
- first error since clear sets errorFlag, errorType and errorAddress (the address registered at that edge).
- later errors do not overwrite while errorFlag=1.
REQ-015 errorClear clears all error status; if clear and a new error occur in the same cycle, the new error SHALL be recorded.
REQ-016 When enable is low, deviceEnable SHALL be all 0, busy=0 and dataRead=0.
REQ-017 localAddress SHALL always equal peripheralBus_address[11:0].
REQ-018 Counter width SHALL be $clog2(TIMEOUT_CYCLES)+1; the counter SHALL be cleared on every return to IDLE.

Reset
REQ-019 rst_n low SHALL asynchronously force:
- state IDLE, counter 0, latched index 0.
- errorFlag 0, errorType 00, errorAddress 16'h0000.
REQ-020 Reset asserted mid-WAIT or mid-ABORT SHALL abandon the access; combinational outputs then follow REQ-007/013/016 from IDLE.
REQ-021 The first rising edge after rst_n deasserts SHALL be a normal IDLE cycle.

Verification
REQ-022 ID_BASE=2, DEVICE_COUNT=4, address 16'h3ABC, slot 1 not busy, data 32'h12345678 -> deviceEnable=4'b0010, localAddress=12'hABC, busy=0, dataRead=32'h12345678, no error.
REQ-023 Address 16'h7000 with enable (unmapped) -> busy=0, dataRead=32'hFFFFFFFF, next cycle errorFlag=1, errorType=01, errorAddress=16'h7000.
REQ-024 TIMEOUT_CYCLES=8, slot busy held high -> busy high for 7 cycles, ABORT on cycle 8 with dataRead=32'hFFFFFFFF, errorType=10; a following good access is not flagged.
REQ-025 Unmapped error followed by timeout without clear -> errorType stays 01; errorClear coincident with a new unmapped access at 16'hF000 -> errorFlag=1, errorAddress=16'hF000.
REQ-026 rst_n pulsed low during WAIT -> all error fields 0, state IDLE; a new access decodes normally on the next cycle.
